// File: rtl/pulse_timing_generator_pkg.sv
// Shared types, limits and config sanitising for the pulse timing generator.
package pulse_timing_generator_pkg;

    // Width at which period/width configuration is sanitised; matches the top's default.
    localparam int unsigned CNT_WIDTH_DEF = 16;

    localparam logic [CNT_WIDTH_DEF-1:0] MIN_PERIOD = CNT_WIDTH_DEF'(2);
    localparam logic [CNT_WIDTH_DEF-1:0] MIN_WIDTH  = CNT_WIDTH_DEF'(1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_WIDTH_DEF-1:0] pl;
        logic [CNT_WIDTH_DEF-1:0] wl;
    } cfg_t;

    // Clamp period to >= 2 and width into [1, period-1].
    function automatic cfg_t sanitise_cfg(input logic [CNT_WIDTH_DEF-1:0] period,
                                          input logic [CNT_WIDTH_DEF-1:0] width);
        cfg_t cfg;
        cfg.pl = (period < MIN_PERIOD) ? MIN_PERIOD : period;
        cfg.wl = (width < MIN_WIDTH) ? MIN_WIDTH : width;
        if (cfg.wl >= cfg.pl) begin
            cfg.wl = cfg.pl - CNT_WIDTH_DEF'(1);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/pulse_interval_counter.sv
// Loadable up-counter with clear and a combinational terminal compare.
module pulse_interval_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] limit_i,
    output logic         at_limit_c_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit_c_o = (count_q == limit_i);

endmodule

// File: rtl/pulse_timing_generator.sv
// Drives Set/Reset strobes of a downstream SR flip-flop to form a programmable pulse train.
module pulse_timing_generator
    import pulse_timing_generator_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 one_shot_i,
    input  logic                 trigger_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] width_i,
    output logic                 set_pulse_o,
    output logic                 reset_pulse_o,
    output logic                 busy_o,
    output logic                 period_done_o
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] pl_q, wl_q;
    logic                 set_q, set_d;
    logic                 rpulse_q, rpulse_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 cfg_latch;
    logic                 cnt_clear, cnt_load, cnt_inc;
    logic                 at_limit_c;
    logic [CNT_WIDTH-1:0] limit_c;
    cfg_t                 cfg_c;

    assign cfg_c   = sanitise_cfg(CNT_WIDTH_DEF'(period_i), CNT_WIDTH_DEF'(width_i));
    assign limit_c = (state_q == HIGH) ? (wl_q - CNT_WIDTH'(1)) : (pl_q - CNT_WIDTH'(1));

    pulse_interval_counter #(
        .W (CNT_WIDTH)
    ) u_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (cnt_clear),
        .load_i       (cnt_load),
        .inc_i        (cnt_inc),
        .load_val_i   (wl_q),
        .limit_i      (limit_c),
        .at_limit_c_o (at_limit_c)
    );

    always_comb begin
        state_d   = state_q;
        set_d     = 1'b0;
        rpulse_d  = 1'b0;
        done_d    = 1'b0;
        cfg_latch = 1'b0;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            INIT: begin
                rpulse_d = 1'b1;
                state_d  = IDLE;
            end
            IDLE: begin
                if (enable_i && (!one_shot_i || trigger_i)) begin
                    cfg_latch = 1'b1;
                    cnt_clear = 1'b1;
                    set_d     = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                // Dropping Enable while high still clears the flip-flop.
                if (!enable_i) begin
                    rpulse_d = 1'b1;
                    state_d  = IDLE;
                end else if (at_limit_c) begin
                    rpulse_d = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = LOW;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            LOW: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (at_limit_c) begin
                    done_d = 1'b1;
                    if (!one_shot_i) begin
                        cfg_latch = 1'b1;
                        cnt_clear = 1'b1;
                        set_d     = 1'b1;
                        state_d   = HIGH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= INIT;
            pl_q     <= '0;
            wl_q     <= '0;
            set_q    <= 1'b0;
            rpulse_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            set_q    <= set_d;
            rpulse_q <= rpulse_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            if (cfg_latch) begin
                pl_q <= CNT_WIDTH'(cfg_c.pl);
                wl_q <= CNT_WIDTH'(cfg_c.wl);
            end
        end
    end

    assign set_pulse_o   = set_q;
    assign reset_pulse_o = rpulse_q;
    assign busy_o        = busy_q;
    assign period_done_o = done_q;

endmodule

// File: tb/tb_pulse_timing_generator.sv
// Directed bench for pulse_timing_generator with a behavioural model of the downstream SR flip-flop.
module tb_pulse_timing_generator;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        one_shot;
    logic        trigger;
    logic [15:0] period;
    logic [15:0] width;
    logic        set_pulse;
    logic        reset_pulse;
    logic        busy;
    logic        period_done;
    logic        ff_q = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;
    int hi_cnt;

    pulse_timing_generator #(
        .CNT_WIDTH (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .one_shot_i    (one_shot),
        .trigger_i     (trigger),
        .period_i      (period),
        .width_i       (width),
        .set_pulse_o   (set_pulse),
        .reset_pulse_o (reset_pulse),
        .busy_o        (busy),
        .period_done_o (period_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SR flip-flop fed by the strobes.
    always @(set_pulse or reset_pulse) begin
        if (set_pulse) ff_q = 1'b1;
        else if (reset_pulse) ff_q = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp = {set, reset, busy, done}
    task automatic expect_out(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {set_pulse, reset_pulse, busy, period_done};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b (set,reset,busy,done)", tag, obs, exp);
        end
        n_checks++;
        assert (!(set_pulse && reset_pulse)) else begin
            n_fails++;
            $error("FAIL %s_excl: observed set=%b reset=%b expected not both high", tag, set_pulse, reset_pulse);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        one_shot = 1'b0;
        trigger  = 1'b0;
        period   = 16'd0;
        width    = 16'd0;

        // Reset and INIT clearing strobe
        #2;
        expect_out("reset_state", 4'b0000);
        step();
        expect_out("reset_hold", 4'b0000);
        rst = 1'b0;
        step();
        expect_out("init_rpulse", 4'b0100);
        expect_int("init_ff_cleared", int'(ff_q), 0);
        step();
        expect_out("idle_a", 4'b0000);
        step();
        expect_out("idle_b", 4'b0000);

        // Free-running, Period 5, Width 2
        period = 16'd5;
        width  = 16'd2;
        enable = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k <= 10; k++) begin
            step();
            expect_out($sformatf("free_k%0d", k),
                       {(k % 5 == 0), (k % 5 == 2), 1'b1, ((k % 5 == 0) && (k > 0))});
            if (k < 10 && ff_q) hi_cnt++;
        end
        expect_int("free_ff_high_cycles", hi_cnt, 4);
        enable = 1'b0;
        step();
        expect_out("free_disable_rpulse", 4'b0100);
        step();
        expect_out("free_idle", 4'b0000);
        expect_int("free_ff_cleared", int'(ff_q), 0);

        // One-shot, Period 4, Width 1, second trigger while busy
        one_shot = 1'b1;
        period   = 16'd4;
        width    = 16'd1;
        enable   = 1'b1;
        trigger  = 1'b1;
        step();
        expect_out("os_t0", 4'b1010);
        trigger = 1'b0;
        step();
        expect_out("os_t1", 4'b0110);
        trigger = 1'b1;
        step();
        expect_out("os_t2", 4'b0010);
        trigger = 1'b0;
        step();
        expect_out("os_t3", 4'b0010);
        step();
        expect_out("os_done", 4'b0001);
        step();
        expect_out("os_idle_a", 4'b0000);
        step();
        expect_out("os_idle_b", 4'b0000);

        // Period 0 / Width 0 clamps to 2 / 1
        one_shot = 1'b0;
        period   = 16'd0;
        width    = 16'd0;
        for (int k = 0; k <= 4; k++) begin
            step();
            expect_out($sformatf("min_k%0d", k),
                       {(k % 2 == 0), (k % 2 == 1), 1'b1, ((k % 2 == 0) && (k > 0))});
        end
        enable = 1'b0;
        step();
        expect_out("min_disable", 4'b0100);

        // Width >= Period clamps to Period-1
        period = 16'd3;
        width  = 16'd9;
        enable = 1'b1;
        step();
        expect_out("clamp_t0", 4'b1010);
        step();
        expect_out("clamp_t1", 4'b0010);
        step();
        expect_out("clamp_t2", 4'b0110);
        step();
        expect_out("clamp_t3", 4'b1011);
        enable = 1'b0;
        step();
        expect_out("clamp_disable", 4'b0100);
        step();
        expect_out("clamp_idle", 4'b0000);

        // Enable dropped at t0+1 during HIGH
        period = 16'd8;
        width  = 16'd4;
        enable = 1'b1;
        step();
        expect_out("drop_t0", 4'b1010);
        step();
        expect_out("drop_t1", 4'b0010);
        enable = 1'b0;
        step();
        expect_out("drop_rpulse", 4'b0100);
        step();
        expect_out("drop_no_done_a", 4'b0000);
        step();
        expect_out("drop_no_done_b", 4'b0000);

        // Asynchronous reset mid-HIGH, then restart
        period = 16'd10;
        width  = 16'd6;
        enable = 1'b1;
        step();
        expect_out("ares_t0", 4'b1010);
        step();
        expect_out("ares_t1", 4'b0010);
        step();
        expect_out("ares_t2", 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        expect_out("ares_immediate", 4'b0000);
        step();
        expect_out("ares_held", 4'b0000);
        rst = 1'b0;
        step();
        expect_out("ares_init_rpulse", 4'b0100);
        expect_int("ares_ff_cleared", int'(ff_q), 0);
        step();
        expect_out("ares_restart", 4'b1010);
        expect_int("ares_ff_set", int'(ff_q), 1);
        step();
        expect_out("ares_restart_t1", 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
